// File: rtl/data_memory_resp_if.sv
// CPU-side load/store handshake bundle for the data memory responder.
interface data_memory_resp_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, ack_o, rdata_o, err_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_memory_resp.sv
// Word-addressed data memory responding to CPU loads/stores after a fixed,
// programmable access latency, with a one-cycle ack and an error flag.
module data_memory_resp #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    data_memory_resp_if.slave   bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata;
    logic [31:0] mem [DEPTH_WORDS];

    logic              accept;
    logic              enter_resp;
    logic              eff_we;
    logic [31:0]       eff_addr;
    logic [31:0]       eff_wdata;
    logic              eff_err;
    logic [ADDR_W-1:0] eff_idx;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        bus.ready_o = 1'b0;
        bus.ack_o   = 1'b0;
        accept      = 1'b0;
        enter_resp  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.req_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                bus.ack_o  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // With LATENCY=1 RESP is entered straight from IDLE, before the latches hold the request.
    always_comb begin
        eff_we    = (state == IDLE) ? bus.we_i    : lat_we;
        eff_addr  = (state == IDLE) ? bus.addr_i  : lat_addr;
        eff_wdata = (state == IDLE) ? bus.wdata_i : lat_wdata;
        eff_err   = addr_err(eff_addr);
        eff_idx   = eff_addr[ADDR_W+1:2];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (accept) begin
                lat_we    <= bus.we_i;
                lat_addr  <= bus.addr_i;
                lat_wdata <= bus.wdata_i;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                if (eff_err)      rdata <= '0;
                else if (!eff_we) rdata <= mem[eff_idx];
            end
        end
    end

    // Array is not reset; writes are gated so nothing lands while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_i && enter_resp && eff_we && !eff_err)
            mem[eff_idx] <= eff_wdata;
    end

    assign bus.rdata_o = rdata;
    assign bus.err_o   = bus.ack_o && addr_err(lat_addr);
endmodule

// File: tb/tb_data_memory_resp.sv
// Bench for data_memory_resp: three instances (LATENCY 2, 1, 15) share one stimulus
// driver; a transaction-level model is compared every cycle alongside literal checks.
module tb_data_memory_resp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    int          sel = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        ready, ack, err;
    logic [31:0] rdata;

    data_memory_resp_if if0 ();
    data_memory_resp_if if1 ();
    data_memory_resp_if if2 ();

    assign if0.req_i = req && (sel == 0);
    assign if1.req_i = req && (sel == 1);
    assign if2.req_i = req && (sel == 2);
    assign if0.we_i = we;    assign if1.we_i = we;    assign if2.we_i = we;
    assign if0.addr_i = addr; assign if1.addr_i = addr; assign if2.addr_i = addr;
    assign if0.wdata_i = wdata; assign if1.wdata_i = wdata; assign if2.wdata_i = wdata;

    always_comb begin
        case (sel)
            1:       begin ready = if1.ready_o; ack = if1.ack_o; err = if1.err_o; rdata = if1.rdata_o; end
            2:       begin ready = if2.ready_o; ack = if2.ack_o; err = if2.err_o; rdata = if2.rdata_o; end
            default: begin ready = if0.ready_o; ack = if0.ack_o; err = if0.err_o; rdata = if0.rdata_o; end
        endcase
    end

    data_memory_resp #(.DEPTH_WORDS(256), .LATENCY(2))  dut0 (.clk_i(clk), .rst_i(rst_n), .bus(if0.slave));
    data_memory_resp #(.DEPTH_WORDS(256), .LATENCY(1))  dut1 (.clk_i(clk), .rst_i(rst_n), .bus(if1.slave));
    data_memory_resp #(.DEPTH_WORDS(256), .LATENCY(15)) dut2 (.clk_i(clk), .rst_i(rst_n), .bus(if2.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int s);
        case (s)
            1:       return 1;
            2:       return 15;
            default: return 2;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Transaction-level model: left = -1 idle, >0 edges until ack, 0 = ack cycle.
    int          left = -1;
    logic [31:0] mmem [3][256];
    bit          mval [3][256];
    logic [31:0] exp_rd [3];
    bit          rd_known [3];
    bit          p_we, p_err;
    logic [31:0] p_addr, p_wdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            left = -1;
            for (int s = 0; s < 3; s++) begin
                exp_rd[s]   = '0;
                rd_known[s] = 1'b1;
            end
        end else if (left == 0) begin
            left = -1;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                if (p_err) begin
                    exp_rd[sel]   = '0;
                    rd_known[sel] = 1'b1;
                end else if (p_we) begin
                    mmem[sel][p_addr / 4] = p_wdata;
                    mval[sel][p_addr / 4] = 1'b1;
                end else begin
                    exp_rd[sel]   = mmem[sel][p_addr / 4];
                    rd_known[sel] = mval[sel][p_addr / 4];
                end
            end
        end
        chk("m_ready", {31'd0, ready}, {31'd0, left < 0});
        chk("m_ack",   {31'd0, ack},   {31'd0, left == 0});
        chk("m_err",   {31'd0, err},   {31'd0, (left == 0) && p_err});
        if (rd_known[sel]) chk("m_rdata", rdata, exp_rd[sel]);
        if (rst_n && left < 0 && req) begin
            left    = lat_of(sel);
            p_we    = we;
            p_addr  = addr;
            p_wdata = wdata;
            p_err   = (addr % 4 != 0) || (addr >= 32'd1024);
        end
    end

    task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err, input logic chk_rd, input logic [31:0] exp_rdata);
        int acc;
        bit got;
        acc = 0;
        @(posedge clk); #2;
        req = 1'b1; we = w; addr = a; wdata = d;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready) begin got = 1'b1; acc = cyc; break; end
        end
        if (!got) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #2;
        req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wdata = ~d;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ack) begin got = 1'b1; break; end
        end
        if (!got) begin
            chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_lat"}, 32'(cyc - acc), 32'(lat_of(sel)));
            chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
            if (chk_rd) chk({tag, "_rdata"}, rdata, exp_rdata);
        end
    endtask

    task automatic burst(input int s, input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
        logic [31:0] al [3];
        logic [31:0] dv [3];
        int acc [3];
        int nacc, nack;
        bit chg;
        al = '{32'h40, 32'h44, 32'h48};
        dv = '{v0, v1, v2};
        acc = '{0, 0, 0};
        nacc = 0; nack = 0; chg = 1'b0;
        @(posedge clk); #2;
        sel = s;
        for (int i = 0; i < 3; i++) txn("pre", 1'b1, al[i], dv[i], 1'b0, 1'b0, '0);
        @(posedge clk); #2;
        req = 1'b1; we = 1'b0; addr = al[0];
        for (int k = 0; k < 200 && nack < 3; k++) begin
            @(negedge clk);
            if (ack) begin
                chk("burst_rdata", rdata, dv[nack]);
                nack++;
            end
            if (req && ready && nacc < 3) begin
                acc[nacc] = cyc;
                nacc++;
                chg = 1'b1;
            end
            @(posedge clk); #2;
            if (chg) begin
                chg = 1'b0;
                if (nacc < 3) addr = al[nacc];
                else begin req = 1'b0; addr = 32'hDEAD_0000; end
            end
        end
        req = 1'b0;
        chk("burst_acks", 32'(nack), 32'd3);
        chk("burst_space01", 32'(acc[1] - acc[0]), 32'(lat_of(s) + 1));
        chk("burst_space12", 32'(acc[2] - acc[1]), 32'(lat_of(s) + 1));
    endtask

    initial begin
        bit got;
        bit saw_ack;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_ack",   {31'd0, ack},   32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_rdata", rdata,          32'd0);

        txn("st10",   1'b1, 32'h10,        32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        txn("ld10",   1'b0, 32'h10,        32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF);
        txn("st04",   1'b1, 32'h4,         32'h1234_5678, 1'b0, 1'b0, '0);
        txn("st06",   1'b1, 32'h6,         32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
        txn("ld04",   1'b0, 32'h4,         32'h0,         1'b0, 1'b1, 32'h1234_5678);
        txn("ld400",  1'b0, 32'h400,       32'h0,         1'b1, 1'b1, 32'h0);
        txn("ld8000", 1'b0, 32'h8000_0000, 32'h0,         1'b1, 1'b1, 32'h0);
        txn("st3fc",  1'b1, 32'h3FC,       32'hA5A5_5A5A, 1'b0, 1'b0, '0);
        txn("ld3fc",  1'b0, 32'h3FC,       32'h0,         1'b0, 1'b1, 32'hA5A5_5A5A);
        txn("st20",   1'b1, 32'h20,        32'h1111_2222, 1'b0, 1'b0, '0);

        // Store aborted by reset while still waiting.
        @(posedge clk); #2;
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready) begin got = 1'b1; break; end
        end
        if (!got) chk("abort_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        req = 1'b0; rst_n = 1'b0;
        saw_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        chk("abort_no_ack", {31'd0, saw_ack}, 32'd0);
        txn("ld20", 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1111_2222);

        burst(0, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
        burst(1, 32'hB000_0011, 32'hB000_0022, 32'hB000_0033);
        burst(2, 32'hC000_0111, 32'hC000_0222, 32'hC000_0333);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
